axi_write_slave: RTL and testbench

- AXI4-style write-channel responder (AW/W/B) and the memory-side counterpart of the core's write initiator.
- Accepts one write transaction at a time: address phase, then data beats, then the write response.
- Each accepted data beat drives a single-cycle byte-strobed write on a simple SRAM-style port.
- Sits between the LSU/cache write path and the backing data memory.

---
 rtl/axi_write_slave_if.sv | 40 ++++
 rtl/axi_write_slave.sv | 148 ++++++++++++++
 tb/tb_axi_write_slave.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_slave_if.sv
// AXI4 write-channel bundle (AW/W/B) shared by initiator and responder.
// Widths are set by the instantiating context.
interface axi_write_slave_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256,
   parameter int STRB_W = DATA_W / 8
);
   logic              AWVALID;
   logic              AWREADY;
   logic [ADDR_W-1:0] AWADDR;
   logic [7:0]        AWLEN;
   logic [2:0]        AWSIZE;
   logic [1:0]        AWBURST;
   logic              WVALID;
   logic              WREADY;
   logic [DATA_W-1:0] WDATA;
   logic [STRB_W-1:0] WSTRB;
   logic              WLAST;
   logic              BVALID;
   logic              BREADY;
   logic [1:0]        BRESP;

   modport master (
      output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
      input  AWREADY,
      output WVALID, WDATA, WSTRB, WLAST,
      input  WREADY,
      input  BVALID, BRESP,
      output BREADY
   );

   modport slave (
      input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
      output AWREADY,
      input  WVALID, WDATA, WSTRB, WLAST,
      output WREADY,
      output BVALID, BRESP,
      input  BREADY
   );
endinterface

// File: rtl/axi_write_slave.sv
// AXI4 write responder: one transaction at a time, each accepted
// beat becomes a single-cycle byte-strobed write on an SRAM port.
module axi_write_slave #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   axi_write_slave_if.slave  axi,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] MAX_SIZE   = 3'($clog2(STRB_W));

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [2:0]        size_q, size_d;
   logic [1:0]        burst_q, burst_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              mem_wen_q, mem_wen_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;

   logic              aw_hs;
   logic              w_hs;
   logic [ADDR_W-1:0] beat_bytes;

   assign aw_hs      = (state_q == IDLE) && axi.AWVALID;
   assign w_hs       = (state_q == DATA) && axi.WVALID && mem_ready;
   assign beat_bytes = ADDR_W'(1) << size_q;

   assign axi.AWREADY = (state_q == IDLE);
   assign axi.WREADY  = (state_q == DATA) && mem_ready;
   assign axi.BVALID  = (state_q == RESP);
   assign axi.BRESP   = err_q ? 2'b10 : 2'b00;

   assign mem_wen   = mem_wen_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

   // Next-state, burst bookkeeping and memory write generation
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      size_d      = size_q;
      burst_d     = burst_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      mem_wen_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      unique case (state_q)
         IDLE: begin
            if (aw_hs) begin
               addr_d  = axi.AWADDR;
               len_d   = axi.AWLEN;
               size_d  = axi.AWSIZE;
               burst_d = axi.AWBURST;
               cnt_d   = 8'd0;
               err_d   = axi.AWBURST[1] ||
                         (axi.AWSIZE > MAX_SIZE);
               state_d = DATA;
            end
         end
         DATA: begin
            if (w_hs) begin
               // Beats past AWLEN or of a bad burst are swallowed
               if (!err_q && (cnt_q <= len_q)) begin
                  mem_wen_d   = 1'b1;
                  mem_addr_d  = addr_q;
                  mem_wdata_d = axi.WDATA;
                  mem_wstrb_d = axi.WSTRB;
               end
               if (cnt_q != 8'hFF) begin
                  cnt_d = cnt_q + 8'd1;
               end
               if (burst_q == BURST_INCR) begin
                  addr_d = addr_q + beat_bytes;
               end
               if (axi.WLAST) begin
                  state_d = RESP;
                  if (cnt_q != len_q) begin
                     err_d = 1'b1;
                  end
               end else if (cnt_q > len_q) begin
                  err_d = 1'b1;
               end
            end
         end
         RESP: begin
            if (axi.BREADY) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
      end
   end

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed bench for axi_write_slave: bursts, errors, stalls,
// response backpressure and mid-burst reset.
module tb_axi_write_slave;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 256;
   localparam int STRB_W = 32;

   logic              ACLK;
   logic              ARESETn;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic              mem_ready;

   int n_chk;
   int n_fail;

   logic [ADDR_W-1:0] wq_addr[$];
   logic [DATA_W-1:0] wq_data[$];
   logic [STRB_W-1:0] wq_strb[$];

   axi_write_slave_if #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)
   ) axi ();

   axi_write_slave #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)
   ) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .axi       (axi),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Record every memory write seen at the falling edge
   always @(negedge ACLK) begin
      if (mem_wen === 1'b1) begin
         wq_addr.push_back(mem_addr);
         wq_data.push_back(mem_wdata);
         wq_strb.push_back(mem_wstrb);
      end
   end

   function automatic logic [DATA_W-1:0] pat(input int k);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(k);
      return {8{w}};
   endfunction

   task automatic clear_q();
      wq_addr.delete();
      wq_data.delete();
      wq_strb.delete();
   endtask

   // Called at a falling edge; returns at the falling edge after the handshake
   task automatic do_aw(input logic [ADDR_W-1:0] a,
                        input logic [7:0] len,
                        input logic [2:0] size,
                        input logic [1:0] burst);
      axi.AWVALID = 1'b1;
      axi.AWADDR  = a;
      axi.AWLEN   = len;
      axi.AWSIZE  = size;
      axi.AWBURST = burst;
      #1;
      for (int i = 0; axi.AWREADY !== 1'b1; i++) begin
         if (i >= 50) begin
            $display("FAIL aw_timeout AWREADY=%b need 1", axi.AWREADY);
            $fatal(1);
         end
         @(negedge ACLK);
      end
      @(negedge ACLK);
      axi.AWVALID = 1'b0;
   endtask

   task automatic do_w(input logic [DATA_W-1:0] d,
                       input logic [STRB_W-1:0] s,
                       input logic last);
      axi.WVALID = 1'b1;
      axi.WDATA  = d;
      axi.WSTRB  = s;
      axi.WLAST  = last;
      #1;
      for (int i = 0; axi.WREADY !== 1'b1; i++) begin
         if (i >= 50) begin
            $display("FAIL w_timeout WREADY=%b need 1", axi.WREADY);
            $fatal(1);
         end
         @(negedge ACLK);
      end
      @(negedge ACLK);
      axi.WVALID = 1'b0;
      axi.WLAST  = 1'b0;
   endtask

   task automatic test_reset();
      ARESETn = 1'b0;
      repeat (2) @(negedge ACLK);
      n_chk++;
      if (axi.AWREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_awready got %b need 1", axi.AWREADY);
      end
      n_chk++;
      if (axi.WREADY !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wready got %b need 0", axi.WREADY);
      end
      n_chk++;
      if (axi.BVALID !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_bvalid got %b need 0", axi.BVALID);
      end
      n_chk++;
      if (axi.BRESP !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_bresp got %b need 00", axi.BRESP);
      end
      n_chk++;
      if (mem_wen !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mem_wen got %b need 0", mem_wen);
      end
      n_chk++;
      if (mem_addr !== '0 || mem_wstrb !== '0 || mem_wdata !== '0) begin
         n_fail++;
         $display("FAIL rst_mem_bus got a=%h s=%h need 0", mem_addr, mem_wstrb);
      end
      ARESETn = 1'b1;
      @(negedge ACLK);
   endtask

   task automatic test_single_beat();
      clear_q();
      axi.BREADY = 1'b1;
      do_aw(32'h8000_0000, 8'd0, 3'd5, 2'b01);
      n_chk++;
      if (axi.AWREADY !== 1'b0 || axi.WREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL single_data_state got awr=%b wr=%b need 0 1",
                  axi.AWREADY, axi.WREADY);
      end
      do_w({8{32'hA5A5_5A5A}}, '1, 1'b1);
      n_chk++;
      if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b00) begin
         n_fail++;
         $display("FAIL single_bresp got v=%b r=%b need 1 00",
                  axi.BVALID, axi.BRESP);
      end
      @(negedge ACLK);
      n_chk++;
      if (axi.BVALID !== 1'b0 || axi.AWREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL single_after_b got bv=%b awr=%b need 0 1",
                  axi.BVALID, axi.AWREADY);
      end
      n_chk++;
      if (wq_addr.size() != 1) begin
         n_fail++;
         $display("FAIL single_count got %0d need 1", wq_addr.size());
      end else begin
         n_chk++;
         if (wq_addr[0] !== 32'h8000_0000 ||
             wq_data[0] !== {8{32'hA5A5_5A5A}} ||
             wq_strb[0] !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL single_write got a=%h s=%h need 80000000 ffffffff",
                     wq_addr[0], wq_strb[0]);
         end
      end
   endtask

   task automatic test_incr_stall();
      logic [ADDR_W-1:0] exp_a;
      clear_q();
      axi.BREADY = 1'b1;
      do_aw(32'h0000_0100, 8'd3, 3'd2, 2'b01);
      do_w(pat(0), 32'h0000_000F, 1'b0);
      mem_ready   = 1'b0;
      axi.WVALID  = 1'b1;
      axi.WDATA   = pat(1);
      axi.WSTRB   = 32'h0000_000F;
      axi.WLAST   = 1'b0;
      #1;
      for (int c = 0; c < 2; c++) begin
         n_chk++;
         if (axi.WREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL incr_stall_wready c%0d got %b need 0", c, axi.WREADY);
         end
         if (c == 0) @(negedge ACLK);
      end
      mem_ready = 1'b1;
      #1;
      n_chk++;
      if (axi.WREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL incr_unstall_wready got %b need 1", axi.WREADY);
      end
      @(negedge ACLK);
      axi.WVALID = 1'b0;
      do_w(pat(2), 32'h0000_000F, 1'b0);
      do_w(pat(3), 32'h0000_000F, 1'b1);
      n_chk++;
      if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b00) begin
         n_fail++;
         $display("FAIL incr_bresp got v=%b r=%b need 1 00",
                  axi.BVALID, axi.BRESP);
      end
      @(negedge ACLK);
      n_chk++;
      if (wq_addr.size() != 4) begin
         n_fail++;
         $display("FAIL incr_count got %0d need 4", wq_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            exp_a = 32'h100 + 32'(4 * i);
            n_chk++;
            if (wq_addr[i] !== exp_a || wq_data[i] !== pat(i)) begin
               n_fail++;
               $display("FAIL incr_beat%0d got a=%h need %h", i, wq_addr[i], exp_a);
            end
         end
      end
   endtask

   task automatic test_fixed();
      logic [STRB_W-1:0] s[3];
      s[0] = 32'h0000_0001;
      s[1] = 32'h0000_00F0;
      s[2] = 32'hFFFF_0000;
      clear_q();
      axi.BREADY = 1'b1;
      do_aw(32'h0000_0040, 8'd2, 3'd5, 2'b00);
      for (int i = 0; i < 3; i++) begin
         do_w(pat(10 + i), s[i], i == 2);
      end
      n_chk++;
      if (axi.BRESP !== 2'b00 || axi.BVALID !== 1'b1) begin
         n_fail++;
         $display("FAIL fixed_bresp got v=%b r=%b need 1 00",
                  axi.BVALID, axi.BRESP);
      end
      @(negedge ACLK);
      n_chk++;
      if (wq_addr.size() != 3) begin
         n_fail++;
         $display("FAIL fixed_count got %0d need 3", wq_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (wq_addr[i] !== 32'h40 || wq_strb[i] !== s[i]) begin
               n_fail++;
               $display("FAIL fixed_beat%0d got a=%h s=%h need 40 %h",
                        i, wq_addr[i], wq_strb[i], s[i]);
            end
         end
      end
   endtask

   task automatic test_bad_burst();
      logic [1:0] bt[2];
      logic [2:0] sz[2];
      bt[0] = 2'b10; sz[0] = 3'd5;
      bt[1] = 2'b01; sz[1] = 3'd6;
      for (int k = 0; k < 2; k++) begin
         clear_q();
         axi.BREADY = 1'b1;
         do_aw(32'h0000_0200, 8'd1, sz[k], bt[k]);
         do_w(pat(20), '1, 1'b0);
         do_w(pat(21), '1, 1'b1);
         n_chk++;
         if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b10) begin
            n_fail++;
            $display("FAIL bad_burst%0d_bresp got v=%b r=%b need 1 10",
                     k, axi.BVALID, axi.BRESP);
         end
         @(negedge ACLK);
         n_chk++;
         if (wq_addr.size() != 0) begin
            n_fail++;
            $display("FAIL bad_burst%0d_writes got %0d need 0", k, wq_addr.size());
         end
      end
   endtask

   task automatic test_early_wlast();
      clear_q();
      axi.BREADY = 1'b1;
      do_aw(32'h0000_0400, 8'd3, 3'd5, 2'b01);
      do_w(pat(30), '1, 1'b0);
      do_w(pat(31), '1, 1'b1);
      n_chk++;
      if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b10) begin
         n_fail++;
         $display("FAIL early_bresp got v=%b r=%b need 1 10",
                  axi.BVALID, axi.BRESP);
      end
      @(negedge ACLK);
      n_chk++;
      if (wq_addr.size() != 2) begin
         n_fail++;
         $display("FAIL early_count got %0d need 2", wq_addr.size());
      end else begin
         n_chk++;
         if (wq_addr[0] !== 32'h400 || wq_addr[1] !== 32'h420) begin
            n_fail++;
            $display("FAIL early_addr got %h %h need 400 420",
                     wq_addr[0], wq_addr[1]);
         end
      end
   endtask

   task automatic test_extra_beat();
      clear_q();
      axi.BREADY = 1'b1;
      do_aw(32'h0000_0500, 8'd0, 3'd5, 2'b01);
      do_w(pat(40), '1, 1'b0);
      do_w(pat(41), '1, 1'b0);
      do_w(pat(42), '1, 1'b1);
      n_chk++;
      if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b10) begin
         n_fail++;
         $display("FAIL extra_bresp got v=%b r=%b need 1 10",
                  axi.BVALID, axi.BRESP);
      end
      @(negedge ACLK);
      n_chk++;
      if (wq_addr.size() != 1 || wq_data[0] !== pat(40)) begin
         n_fail++;
         $display("FAIL extra_count got %0d need 1", wq_addr.size());
      end
   endtask

   task automatic test_back_to_back();
      clear_q();
      axi.BREADY = 1'b0;
      do_aw(32'h0000_0600, 8'd0, 3'd5, 2'b01);
      do_w(pat(50), '1, 1'b1);
      for (int c = 0; c < 5; c++) begin
         n_chk++;
         if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b00 ||
             axi.AWREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_c%0d got bv=%b r=%b awr=%b need 1 00 0",
                     c, axi.BVALID, axi.BRESP, axi.AWREADY);
         end
         @(negedge ACLK);
      end
      axi.BREADY = 1'b1;
      @(negedge ACLK);
      n_chk++;
      if (axi.BVALID !== 1'b0 || axi.AWREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_release got bv=%b awr=%b need 0 1",
                  axi.BVALID, axi.AWREADY);
      end
      do_aw(32'h0000_0620, 8'd0, 3'd5, 2'b01);
      do_w(pat(51), '1, 1'b1);
      @(negedge ACLK);
      n_chk++;
      if (wq_addr.size() != 2 || wq_addr[1] !== 32'h620) begin
         n_fail++;
         $display("FAIL b2b_writes got n=%0d need 2", wq_addr.size());
      end
   endtask

   task automatic test_reset_mid_burst();
      clear_q();
      axi.BREADY = 1'b1;
      do_aw(32'h0000_0700, 8'd3, 3'd5, 2'b01);
      do_w(pat(60), '1, 1'b0);
      do_w(pat(61), '1, 1'b0);
      axi.WVALID = 1'b1;
      axi.WDATA  = pat(62);
      axi.WSTRB  = '1;
      axi.WLAST  = 1'b0;
      @(posedge ACLK);
      #2;
      ARESETn = 1'b0;
      #1;
      n_chk++;
      if (mem_wen !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_mem_wen got %b need 0", mem_wen);
      end
      n_chk++;
      if (axi.AWREADY !== 1'b1 || axi.WREADY !== 1'b0 ||
          axi.BVALID !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_hs got awr=%b wr=%b bv=%b need 1 0 0",
                  axi.AWREADY, axi.WREADY, axi.BVALID);
      end
      @(negedge ACLK);
      axi.WVALID = 1'b0;
      @(negedge ACLK);
      ARESETn = 1'b1;
      n_chk++;
      if (wq_addr.size() != 2) begin
         n_fail++;
         $display("FAIL midrst_writes got %0d need 2", wq_addr.size());
      end
      clear_q();
      do_aw(32'h0000_0800, 8'd0, 3'd5, 2'b01);
      do_w(pat(63), '1, 1'b1);
      n_chk++;
      if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b00) begin
         n_fail++;
         $display("FAIL midrst_after_bresp got v=%b r=%b need 1 00",
                  axi.BVALID, axi.BRESP);
      end
      @(negedge ACLK);
      n_chk++;
      if (wq_addr.size() != 1 || wq_addr[0] !== 32'h800 ||
          wq_data[0] !== pat(63)) begin
         n_fail++;
         $display("FAIL midrst_after_write got n=%0d need 1", wq_addr.size());
      end
   endtask

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      ARESETn     = 1'b0;
      mem_ready   = 1'b1;
      axi.AWVALID = 1'b0;
      axi.AWADDR  = '0;
      axi.AWLEN   = '0;
      axi.AWSIZE  = '0;
      axi.AWBURST = '0;
      axi.WVALID  = 1'b0;
      axi.WDATA   = '0;
      axi.WSTRB   = '0;
      axi.WLAST   = 1'b0;
      axi.BREADY  = 1'b0;
      @(negedge ACLK);
      test_reset();
      test_single_beat();
      test_incr_stall();
      test_fixed();
      test_bad_burst();
      test_early_wlast();
      test_extra_beat();
      test_back_to_back();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
